// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: request/acknowledge bus between the fetch unit and instruction memory
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic imem_req;
  logic imem_ack;
  logic [31:0] imem_instruction;
  modport master (output imem_address, imem_req, input imem_ack, imem_instruction);
  modport slave (input imem_address, imem_req, output imem_ack, imem_instruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, requests instruction words and queues them for decode
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master imem,
  input logic stall,
  input logic redirect,
  input logic [31:0] redirect_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic if_valid
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(QUEUE_DEPTH);
  typedef enum logic {FETCH, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, pending_pc, pending_pc_n, target;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] pc_q [QUEUE_DEPTH];
  logic [31:0] instr_q [QUEUE_DEPTH];
  logic xfer, push, pop;
  assign target = {redirect_pc[31:2], 2'b00};
  assign if_valid = count != '0;
  assign if_pc = if_valid ? pc_q[rd_ptr] : '0;
  assign if_instruction = if_valid ? instr_q[rd_ptr] : '0;
  // DISCARD keeps the outstanding request alive until memory answers, then drops that word
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    pending_pc_n = redirect ? target : pending_pc;
    imem.imem_req = reset && (state == DISCARD || count < FULL);
    imem.imem_address = fetch_pc;
    xfer = imem.imem_req && imem.imem_ack;
    push = state == FETCH && xfer && !redirect;
    pop = if_valid && !stall;
    if (state == DISCARD) begin
      if (imem.imem_ack) begin
        state_n = FETCH;
        fetch_pc_n = pending_pc_n;
      end
    end else if (redirect) begin
      if (imem.imem_req && !imem.imem_ack) state_n = DISCARD;
      else fetch_pc_n = target;
    end else if (xfer) begin
      fetch_pc_n = fetch_pc + 32'd4;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      pending_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      pending_pc <= pending_pc_n;
      if (redirect) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= fetch_pc;
      instr_q[wr_ptr] <= imem.imem_instruction;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch unit with a word(addr)=addr/4+1 memory
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0, stall = 1'b1, redirect = 1'b0, ack = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_pc, if_instruction, w_pc, w_instruction;
  logic if_valid, w_valid;
  logic wmon_en = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] wsb[$];
  int n_checks = 0, n_pass = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction
  instruction_fetch_unit_if bus();
  instruction_fetch_unit_if wbus();
  assign bus.imem_ack = ack;
  assign bus.imem_instruction = word(bus.imem_address);
  assign wbus.imem_ack = 1'b1;
  assign wbus.imem_instruction = word(wbus.imem_address);
  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .imem(bus.master), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid)
  );
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset), .imem(wbus.master), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .if_pc(w_pc), .if_instruction(w_instruction), .if_valid(w_valid)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic ack_v, input logic stall_v);
    stall = 1'b1;
    redirect = 1'b0;
    ack = ack_v;
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rst valid", 32'(if_valid), 32'd0);
    check("rst pc", if_pc, 32'd0);
    check("rst req", 32'(bus.imem_req), 32'd0);
    check("rst addr", bus.imem_address, 32'd0);
    tick();
    reset = 1'b1;
    stall = stall_v;
  endtask
  always @(negedge clk) begin
    if (reset && if_valid && !stall && !redirect) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious pop: got pc %h expected none", if_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("pop pc", if_pc, e);
        check("pop instr", if_instruction, word(e));
      end
    end
  end
  always @(negedge clk) begin
    if (wmon_en && w_valid) begin
      if (wsb.size() == 0) begin
        n_checks++;
        $display("FAIL wrap spurious pop: got pc %h expected none", w_pc);
      end else begin
        logic [31:0] e;
        e = wsb.pop_front();
        check("wrap pc", w_pc, e);
        check("wrap instr", w_instruction, word(e));
      end
    end
  end
  initial begin
    start(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) wsb.push_back(32'hFFFF_FFF8 + 32'(i * 4));
    wmon_en = 1'b1;
    @(negedge clk);
    check("t1 first valid early", 32'(if_valid), 32'd0);
    repeat (5) tick();
    stall = 1'b1;
    wmon_en = 1'b0;
    check("t1 drain", 32'(sb.size()), 32'd0);
    check("t5 drain", 32'(wsb.size()), 32'd0);
    start(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) sb.push_back(32'(i * 4));
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2 req while full", 32'(bus.imem_req), 32'd0);
      check("t2 held pc", if_pc, 32'd0);
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2 no gap", 32'(if_valid), 32'd1);
      tick();
    end
    stall = 1'b1;
    check("t2 drain", 32'(sb.size()), 32'd0);
    start(1'b1, 1'b1);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("t3 valid after redirect", 32'(if_valid), 32'd0);
    check("t3 addr", bus.imem_address, 32'h100);
    check("t3 req", 32'(bus.imem_req), 32'd1);
    tick();
    @(negedge clk);
    check("t3 first pc", if_pc, 32'h100);
    tick();
    tick();
    stall = 1'b1;
    check("t3 drain", 32'(sb.size()), 32'd0);
    start(1'b0, 1'b0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4 req held", 32'(bus.imem_req), 32'd1);
      check("t4 addr held", bus.imem_address, 32'd0);
      check("t4 no push", 32'(if_valid), 32'd0);
      tick();
      redirect = 1'b0;
      if (i == 2) ack = 1'b1;
    end
    @(negedge clk);
    check("t4 new addr", bus.imem_address, 32'h200);
    check("t4 dropped", 32'(if_valid), 32'd0);
    tick();
    tick();
    tick();
    stall = 1'b1;
    check("t4 drain", 32'(sb.size()), 32'd0);
    start(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) sb.push_back(32'(i * 4));
    repeat (4) tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6 req in reset", 32'(bus.imem_req), 32'd0);
    check("t6 drain pre", 32'(sb.size()), 32'd0);
    tick();
    reset = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    @(negedge clk);
    check("t6 valid", 32'(if_valid), 32'd0);
    check("t6 pc", if_pc, 32'd0);
    check("t6 restart addr", bus.imem_address, 32'd0);
    repeat (3) tick();
    stall = 1'b1;
    check("t6 drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
